// File: rtl/alu_pipe_mc.sv
// alu_pipe_mc: execute-stage ALU with valid/ready handshakes on both sides.
//
// Bitwise ops, saturating ADD/SUB and zero-length shifts finish on the accepting
// edge. Shifts by s > 0 take s more edges, one bit per edge. MUL is an unsigned
// shift-add multiply and takes WIDTH more edges. Result and flags are registered.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The producer holds its payload stable until that edge. The consumer may
// raise or drop ready at any time. A result stays offered, unchanged, until it
// is taken.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operation handshake; A, B, Alu_Ctrl latched on transfer
//   A, B                operands; B[SHW-1:0] is the shift amount
//   Alu_Ctrl            opcode
//   out_valid/out_ready result handshake
//   Result, z, n, v     registered result, zero/negative/overflow flags
//   state_dbg           current FSM state (IDLE=0, BUSY=1, DONE=2)
module alu_pipe_mc #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Alu_Ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             z,
    output logic             n,
    output logic             v,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_NAND = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1100;
    localparam logic [3:0] OP_SRL  = 4'b1101;
    localparam logic [3:0] OP_SRA  = 4'b1110;

    // Counter must hold WIDTH (MUL step count), hence one bit wider than SHW.
    localparam int CNT_W = SHW + 1;
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_q,  state_d;
    logic [3:0]         op_q,     op_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   work_q,   work_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               z_q, z_d, n_q, n_d, v_q, v_d;

    logic               accept;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   sum, diff, imm_res, shifted;
    logic               add_ovf, sub_ovf, imm_v;
    logic [2*WIDTH-1:0] acc_step;
    logic               fin_en, fin_v;
    logic [WIDTH-1:0]   fin_res;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign shamt     = B[SHW-1:0];
    assign Result    = result_q;
    assign z         = z_q;
    assign n         = n_q;
    assign v         = v_q;
    assign state_dbg = state_q;

    // Single-cycle results straight from the input operands.
    always_comb begin
        sum     = A + B;
        diff    = A - B;
        // Signed overflow: like-signed add or unlike-signed subtract whose
        // result sign differs from A. Saturate toward A's sign.
        add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1]  != A[WIDTH-1]);
        sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
        imm_res = '0;
        imm_v   = 1'b0;
        case (Alu_Ctrl)
            OP_ADD:  begin imm_res = add_ovf ? (A[WIDTH-1] ? SAT_MIN : SAT_MAX) : sum;  imm_v = add_ovf; end
            OP_SUB:  begin imm_res = sub_ovf ? (A[WIDTH-1] ? SAT_MIN : SAT_MAX) : diff; imm_v = sub_ovf; end
            OP_NAND: imm_res = ~(A & B);
            OP_XOR:  imm_res = A ^ B;
            OP_SLL, OP_SRL, OP_SRA: imm_res = A;   // only reached with shamt == 0
            default: imm_res = '0;
        endcase
    end

    // One iteration of the multi-cycle datapaths.
    always_comb begin
        case (op_q)
            OP_SLL:  shifted = {work_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, work_q[WIDTH-1:1]};
            default: shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        endcase
        acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        z_d      = z_q;
        n_d      = n_q;
        v_d      = v_q;
        fin_en   = 1'b0;
        fin_res  = '0;
        fin_v    = 1'b0;

        case (state_q)
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (op_q == OP_MUL) begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (cnt_q == CNT_W'(1)) begin
                        fin_en  = 1'b1;
                        fin_res = acc_step[WIDTH-1:0];
                        fin_v   = |acc_step[2*WIDTH-1:WIDTH];
                    end
                end else begin
                    work_d = shifted;
                    if (cnt_q == CNT_W'(1)) begin
                        fin_en  = 1'b1;
                        fin_res = shifted;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;   // a same-cycle accept overrides below
            end
            default: ;
        endcase

        if (accept) begin
            op_d = Alu_Ctrl;
            if ((Alu_Ctrl == OP_SLL || Alu_Ctrl == OP_SRL || Alu_Ctrl == OP_SRA) && shamt != '0) begin
                work_d  = A;
                cnt_d   = {1'b0, shamt};
                state_d = BUSY;
            end else if (Alu_Ctrl == OP_MUL) begin
                acc_d    = '0;
                mcand_d  = {{WIDTH{1'b0}}, A};
                mplier_d = B;
                cnt_d    = CNT_W'(WIDTH);
                state_d  = BUSY;
            end else begin
                fin_en  = 1'b1;
                fin_res = imm_res;
                fin_v   = imm_v;
            end
        end

        // Flags are taken from the final (post-saturation) value.
        if (fin_en) begin
            result_d = fin_res;
            z_d      = (fin_res == '0);
            n_d      = fin_res[WIDTH-1];
            v_d      = fin_v;
            state_d  = DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            work_q   <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            z_q      <= z_d;
            n_q      <= n_d;
            v_q      <= v_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe_mc.sv
// tb_alu_pipe_mc: directed-vector bench for alu_pipe_mc (WIDTH=16).
// Inputs are driven just after edges; outputs are sampled on the falling edge.
module tb_alu_pipe_mc;

    localparam int W = 16;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_BAD  = 4'b0011;
    localparam logic [3:0] OP_NAND = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1100;
    localparam logic [3:0] OP_SRL  = 4'b1101;
    localparam logic [3:0] OP_SRA  = 4'b1110;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   Alu_Ctrl;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Result;
    logic         z, n, v;
    logic [1:0]   state_dbg;

    int total = 0;
    int bad   = 0;

    alu_pipe_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Alu_Ctrl  (Alu_Ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .z         (z),
        .n         (n),
        .v         (v),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Call just after a falling edge. Offers an op, waits (bounded) for in_ready,
    // completes the transfer on the next rising edge and then scrambles the bus.
    task automatic drive_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard = 0;
        Alu_Ctrl = op; A = a; B = b; in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; A = 16'hDEAD; B = 16'hBEEF; Alu_Ctrl = OP_SLL;
    endtask

    // Counts rising edges after the accepting edge until out_valid is seen
    // (-1 on timeout) and how many of those waiting cycles showed in_ready=1.
    task automatic wait_done(output int lat, output int rdy_seen);
        bit done = 0;
        lat = 0;
        rdy_seen = 0;
        while (!done) begin
            @(negedge clk);
            if (out_valid) done = 1;
            else begin
                if (in_ready) rdy_seen++;
                lat++;
                if (lat > 100) begin lat = -1; done = 1; end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Alu_Ctrl = OP_ADD;
        #1 rst_n = 1'b0;
        #2;
        total++;
        if ({out_valid, Result, z, n, v, state_dbg} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got ov=%b res=%h znv=%b%b%b st=%0d req all zero",
                     out_valid, Result, z, n, v, state_dbg);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%b req=1", in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({out_valid, Result, state_dbg} !== '0) begin
            bad++; $display("FAIL reset_release got ov=%b res=%h st=%0d req zero", out_valid, Result, state_dbg);
        end
    endtask

    task automatic test_add();
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        logic [W-1:0] vr [3];
        logic [2:0]   vf [3];   // {z,n,v}
        int lat, rdy;
        va = '{16'h7FFF, 16'h0003, 16'h8000};
        vb = '{16'h0001, 16'hFFFD, 16'hFFFF};
        vr = '{16'h7FFF, 16'h0000, 16'h8000};
        vf = '{3'b001,   3'b100,   3'b011};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_op(OP_ADD, va[i], vb[i]);
            wait_done(lat, rdy);
            total++;
            if (lat !== 0) begin bad++; $display("FAIL add_latency[%0d] got=%0d req=0", i, lat); end
            total++;
            if (Result !== vr[i]) begin bad++; $display("FAIL add_result[%0d] got=%h req=%h", i, Result, vr[i]); end
            total++;
            if ({z, n, v} !== vf[i]) begin bad++; $display("FAIL add_flags[%0d] got znv=%b req=%b", i, {z, n, v}, vf[i]); end
        end
    endtask

    task automatic test_sub_logic();
        logic [3:0]   vo [5];
        logic [W-1:0] va [5];
        logic [W-1:0] vb [5];
        logic [W-1:0] vr [5];
        logic [2:0]   vf [5];
        int lat, rdy;
        vo = '{OP_SUB,   OP_NAND,  OP_XOR,   OP_BAD,   OP_SUB};
        va = '{16'h8000, 16'hFFFF, 16'h00FF, 16'hFFFF, 16'h0005};
        vb = '{16'h0001, 16'hFFFF, 16'h0F0F, 16'hFFFF, 16'h0007};
        vr = '{16'h8000, 16'h0000, 16'h0FF0, 16'h0000, 16'hFFFE};
        vf = '{3'b011,   3'b100,   3'b000,   3'b100,   3'b010};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_op(vo[i], va[i], vb[i]);
            wait_done(lat, rdy);
            total++;
            if (lat !== 0) begin bad++; $display("FAIL op1_latency[%0d] got=%0d req=0", i, lat); end
            total++;
            if (Result !== vr[i]) begin bad++; $display("FAIL op1_result[%0d] got=%h req=%h", i, Result, vr[i]); end
            total++;
            if ({z, n, v} !== vf[i]) begin bad++; $display("FAIL op1_flags[%0d] got znv=%b req=%b", i, {z, n, v}, vf[i]); end
        end
    endtask

    task automatic test_shift();
        logic [3:0]   vo [6];
        logic [W-1:0] va [6];
        logic [W-1:0] vb [6];
        logic [W-1:0] vr [6];
        int           vl [6];
        logic [2:0]   vf [6];
        int lat, rdy;
        vo = '{OP_SRA,   OP_SRL,   OP_SLL,   OP_SLL,   OP_SRL,   OP_SRA};
        va = '{16'h8000, 16'h8000, 16'h0001, 16'hABCD, 16'h1234, 16'h7F00};
        vb = '{16'h0004, 16'h0004, 16'h000F, 16'h0000, 16'h0010, 16'h0003};
        vr = '{16'hF800, 16'h0800, 16'h8000, 16'hABCD, 16'h1234, 16'h0FE0};
        vl = '{4,        4,        15,       0,        0,        3};
        vf = '{3'b010,   3'b000,   3'b010,   3'b010,   3'b000,   3'b000};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_op(vo[i], va[i], vb[i]);
            wait_done(lat, rdy);
            total++;
            if (lat !== vl[i]) begin bad++; $display("FAIL shift_latency[%0d] got=%0d req=%0d", i, lat, vl[i]); end
            total++;
            if (rdy !== 0) begin bad++; $display("FAIL shift_busy_ready[%0d] got %0d ready cycles req=0", i, rdy); end
            total++;
            if (Result !== vr[i]) begin bad++; $display("FAIL shift_result[%0d] got=%h req=%h", i, Result, vr[i]); end
            total++;
            if ({z, n, v} !== vf[i]) begin bad++; $display("FAIL shift_flags[%0d] got znv=%b req=%b", i, {z, n, v}, vf[i]); end
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] va [4];
        logic [W-1:0] vb [4];
        logic [W-1:0] vr [4];
        logic [2:0]   vf [4];
        int lat, rdy;
        va = '{16'h0100, 16'h0003, 16'hFFFF, 16'h00FF};
        vb = '{16'h0100, 16'h0005, 16'h0002, 16'h0101};
        vr = '{16'h0000, 16'h000F, 16'hFFFE, 16'hFFFF};
        vf = '{3'b101,   3'b000,   3'b011,   3'b010};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_op(OP_MUL, va[i], vb[i]);
            wait_done(lat, rdy);
            total++;
            if (lat !== 16) begin bad++; $display("FAIL mul_latency[%0d] got=%0d req=16", i, lat); end
            total++;
            if (rdy !== 0) begin bad++; $display("FAIL mul_busy_ready[%0d] got %0d ready cycles req=0", i, rdy); end
            total++;
            if (Result !== vr[i]) begin bad++; $display("FAIL mul_result[%0d] got=%h req=%h", i, Result, vr[i]); end
            total++;
            if ({z, n, v} !== vf[i]) begin bad++; $display("FAIL mul_flags[%0d] got znv=%b req=%b", i, {z, n, v}, vf[i]); end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        out_ready = 1'b1;
        drive_op(OP_ADD, 16'h0010, 16'h0020);
        // Offer the next op right away; DONE with out_ready=1 accepts it.
        Alu_Ctrl = OP_XOR; A = 16'hF0F0; B = 16'h0FF0; in_valid = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || Result !== 16'h0030) begin
            bad++; $display("FAIL b2b_first got ov=%b res=%h req ov=1 res=0030", out_valid, Result);
        end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b req=1", in_ready); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || Result !== 16'hFF00 || {z, n, v} !== 3'b010) begin
            bad++; $display("FAIL b2b_second got ov=%b res=%h znv=%b req ov=1 res=ff00 znv=010",
                            out_valid, Result, {z, n, v});
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got ov=%b req=0", out_valid); end
    endtask

    task automatic test_backpressure();
        int lat, rdy;
        @(negedge clk);
        out_ready = 1'b0;
        drive_op(OP_XOR, 16'h1234, 16'hFFFF);
        wait_done(lat, rdy);
        total++;
        if (lat !== 0 || Result !== 16'hEDCB) begin
            bad++; $display("FAIL bp_first got lat=%0d res=%h req lat=0 res=edcb", lat, Result);
        end
        for (int i = 0; i < 3; i++) begin
            A = 16'($urandom_range(0, 16'hFFFF));
            B = 16'($urandom_range(0, 16'hFFFF));
            Alu_Ctrl = OP_ADD;
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || Result !== 16'hEDCB || {z, n, v} !== 3'b010) begin
                bad++; $display("FAIL bp_hold[%0d] got ov=%b rdy=%b res=%h znv=%b req ov=1 rdy=0 res=edcb znv=010",
                                i, out_valid, in_ready, Result, {z, n, v});
            end
        end
        out_ready = 1'b1;
        Alu_Ctrl = OP_ADD; A = 16'h0001; B = 16'h0001; in_valid = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b req=1", in_ready); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || Result !== 16'h0002 || {z, n, v} !== 3'b000) begin
            bad++; $display("FAIL bp_new_result got ov=%b res=%h znv=%b req ov=1 res=0002 znv=000",
                            out_valid, Result, {z, n, v});
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || state_dbg !== 2'd0) begin
            bad++; $display("FAIL bp_idle got ov=%b st=%0d req ov=0 st=0", out_valid, state_dbg);
        end
    endtask

    task automatic test_async_reset();
        int lat, rdy;
        int stale = 0;
        @(negedge clk);
        out_ready = 1'b1;
        drive_op(OP_XOR, 16'h00FF, 16'h0F0F);
        wait_done(lat, rdy);
        total++;
        if (Result !== 16'h0FF0) begin bad++; $display("FAIL ar_pre_result got=%h req=0ff0", Result); end
        drive_op(OP_SLL, 16'h0001, 16'h000A);
        repeat (4) @(negedge clk);
        total++;
        if (state_dbg !== 2'd1) begin bad++; $display("FAIL ar_busy got st=%0d req=1", state_dbg); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, Result, z, n, v, state_dbg} !== '0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL ar_clear got ov=%b res=%h znv=%b%b%b st=%0d rdy=%b req zeros rdy=1",
                            out_valid, Result, z, n, v, state_dbg, in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) stale++;
        end
        total++;
        if (stale !== 0) begin bad++; $display("FAIL ar_no_stale got %0d bad cycles req=0", stale); end
        drive_op(OP_ADD, 16'h0005, 16'h0003);
        wait_done(lat, rdy);
        total++;
        if (lat !== 0 || Result !== 16'h0008 || {z, n, v} !== 3'b000) begin
            bad++; $display("FAIL ar_fresh_add got lat=%0d res=%h znv=%b req lat=0 res=0008 znv=000",
                            lat, Result, {z, n, v});
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_add();
        test_sub_logic();
        test_shift();
        test_mul();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
